// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter: N producers share one registered output stage.
// Each output beat is tagged with its source index, and completed packets are counted.
// Optional macro ARB_PKT_LOCK_EN: when defined, a grant is held until the end of a packet.
// When the macro is undefined, the grant is released after every accepted beat.
module axis_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]    s_tvalid,
    input  logic [N-1:0]    s_tlast,
    output logic [N-1:0]    s_tready,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tvalid,
    output logic            m_tlast,
    output logic [IW-1:0]   m_tid,
    input  logic            m_tready,
    output logic [N-1:0]    grant,
    output logic [15:0]     pkt_cnt
);

    localparam int unsigned CW = 16;

    typedef enum logic {ARB, XFER} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [DW-1:0] m_tdata_q, m_tdata_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          m_tlast_q, m_tlast_d;
    logic [IW-1:0] m_tid_q, m_tid_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

    logic          any_valid;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] cand_idx;
    logic          out_ready;
    logic          accept;
    logic          release_grant;
    logic [DW-1:0] g_data;
    logic          g_last;

    // Round-robin pick: first valid stream searching upward from last+1
    always_comb begin
        any_valid = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand_idx = IW'((32'(last_q) + 32'd1 + k) % N);
            if (!any_valid && s_tvalid[cand_idx]) begin
                any_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Granted-stream datapath; last_q holds the granted index while in XFER
    always_comb begin
        g_data = s_tdata[32'(last_q) * DW +: DW];
        g_last = s_tlast[last_q];
    end

    // Next-state and handshake logic for arbiter FSM and output register
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;
        pkt_cnt_d  = pkt_cnt_q;

        // The output slot is free when empty or draining this cycle
        out_ready = ~m_tvalid_q | m_tready;
        s_tready  = grant_q & {N{out_ready}};
        accept    = |(s_tvalid & s_tready);

`ifdef ARB_PKT_LOCK_EN
        release_grant = accept & g_last;
`else
        release_grant = accept;
`endif

        case (state_q)
            ARB: begin
                if (any_valid) begin
                    grant_d = N'(1) << sel_idx;
                    last_d  = sel_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (release_grant) begin
                    grant_d = '0;
                    state_d = ARB;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ARB;
            end
        endcase

        if (accept) begin
            m_tdata_d  = g_data;
            m_tlast_d  = g_last;
            m_tid_d    = last_q;
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (m_tvalid_q && m_tready && m_tlast_q) begin
            pkt_cnt_d = pkt_cnt_q + CW'(1);
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB;
            grant_q    <= '0;
            last_q     <= IW'(N - 1);
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tid_q    <= m_tid_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign grant    = grant_q;
    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tid    = m_tid_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter (N=4, DW=32); checks both grant modes.
module tb_axis_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic [IW-1:0]   m_tid;
    logic            m_tready;
    logic [N-1:0]    grant;
    logic [15:0]     pkt_cnt;

    always #5 clk = ~clk;

    axis_rr_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .m_tready (m_tready),
        .grant    (grant),
        .pkt_cnt  (pkt_cnt)
    );

    typedef struct packed {
        logic [IW-1:0] tid;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [3:0]  vld;
        logic        mr;
        logic [3:0]  e_grant;
        logic [3:0]  e_rdy;
        logic        e_mv;
        logic [1:0]  e_tid;
        logic [31:0] e_data;
        logic [15:0] e_pkt;
    } vec_t;

    int    passed = 0;
    int    total  = 0;
    int    rem  [N];
    int    bidx [N];
    int    plen [N];
    logic [DW-1:0] base [N];
    beat_t q[$];
    logic  stalled;
    beat_t held;
    vec_t  tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic mr, input logic [3:0] eg,
                                input logic [3:0] er, input logic emv, input logic [1:0] etid,
                                input logic [31:0] ed, input logic [15:0] ep);
        vec_t r;
        r.vld = v; r.mr = mr; r.e_grant = eg; r.e_rdy = er;
        r.e_mv = emv; r.e_tid = etid; r.e_data = ed; r.e_pkt = ep;
        return r;
    endfunction

    // Producer model: stream i offers base+bidx while beats remain
    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]          = (rem[i] > 0);
            s_tdata[i*DW +: DW]  = base[i] + DW'(bidx[i]);
            s_tlast[i]           = (((bidx[i] + 1) % plen[i]) == 0);
        end
    endtask

    // One cycle: drive, check stall rules, log handshakes, advance to next negedge
    task automatic tick();
        drive_sources();
        #1;
        if (stalled) check("stall_hold", 64'({m_tid, m_tlast, m_tdata}), 64'(held));
        if (m_tvalid && !m_tready) check("stall_rdy", 64'(s_tready), 64'd0);
        stalled = m_tvalid && !m_tready;
        held    = {m_tid, m_tlast, m_tdata};
        if (m_tvalid && m_tready) q.push_back({m_tid, m_tlast, m_tdata});
        for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i]) begin
                bidx[i]++;
                rem[i]--;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; bidx[i] = 0; plen[i] = 1; base[i] = '0;
        end
        drive_sources();
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        stalled = 1'b0;
        q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] pat;
        int kexp;
        pat = 6'b101001; // m_tready sequence 1,0,0,1,0,1 read from bit 0 upward
        @(negedge clk);

        // Reset and idle
        do_reset();
        for (int c = 0; c < 20; c++) begin
            drive_sources();
            #1;
            check($sformatf("idle%0d", c),
                  64'({grant, s_tready, m_tvalid, m_tlast, m_tid, m_tdata, pkt_cnt}), 64'd0);
            @(negedge clk);
        end

        // Table: single-beat packets, identical in both grant modes
        tbl[0] = mk(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0,  16'd0);
        tbl[1] = mk(4'b1010, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0,  16'd0);
        tbl[2] = mk(4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b0, 2'd0, 32'h0,  16'd0);
        tbl[3] = mk(4'b1000, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd1, 32'hA1, 16'd0);
        tbl[4] = mk(4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b0, 2'd0, 32'h0,  16'd1);
        tbl[5] = mk(4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, 32'hA3, 16'd1);
        tbl[6] = mk(4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd3, 32'hA3, 16'd1);
        tbl[7] = mk(4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 2'd3, 32'hA3, 16'd1);
        tbl[8] = mk(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd0, 32'hA0, 16'd2);
        tbl[9] = mk(4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0,  16'd3);
        do_reset();
        for (int r = 0; r < 10; r++) begin
            s_tvalid = tbl[r].vld;
            s_tlast  = '1;
            for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = 32'hA0 + 32'(i);
            m_tready = tbl[r].mr;
            #1;
            check($sformatf("vec%0d_grant", r), 64'(grant), 64'(tbl[r].e_grant));
            check($sformatf("vec%0d_rdy", r), 64'(s_tready), 64'(tbl[r].e_rdy));
            check($sformatf("vec%0d_mvalid", r), 64'(m_tvalid), 64'(tbl[r].e_mv));
            check($sformatf("vec%0d_pkt", r), 64'(pkt_cnt), 64'(tbl[r].e_pkt));
            if (tbl[r].e_mv) begin
                check($sformatf("vec%0d_out", r), 64'({m_tid, m_tlast, m_tdata}),
                      64'({tbl[r].e_tid, 1'b1, tbl[r].e_data}));
            end
            @(negedge clk);
        end

        // Single stream: 4-beat packet on stream 2
        do_reset();
        rem[2] = 4; plen[2] = 4; base[2] = 32'h10;
        tick();
        check("ss_grant", 64'(grant), 64'b0100);
        check("ss_rdy", 64'(s_tready), 64'b0100);
        check("ss_mv_t1", 64'(m_tvalid), 64'd0);
        tick();
        check("ss_mv_t2", 64'(m_tvalid), 64'd1);
        for (int c = 0; c < 20 && !(q.size() == 4 && !m_tvalid); c++) tick();
        check("ss_count", 64'(q.size()), 64'd4);
        for (int k = 0; k < 4 && k < q.size(); k++) begin
            check($sformatf("ss_beat%0d", k), 64'(q[k]),
                  64'({2'd2, (k == 3) ? 1'b1 : 1'b0, 32'h10 + 32'(k)}));
        end
        check("ss_pkt", 64'(pkt_cnt), 64'd1);

        // Fairness: all streams offer 2-beat packets continuously
        do_reset();
        for (int i = 0; i < N; i++) begin
            rem[i] = 10; plen[i] = 2; base[i] = DW'(i) << 8;
        end
        repeat (40) tick();
`ifdef ARB_PKT_LOCK_EN
        kexp = 10;
`else
        kexp = 8;
`endif
        check("fair_count_ok", 64'(q.size() >= kexp), 64'd1);
        for (int j = 0; j < kexp && j < q.size(); j++) begin
            int s, ix;
`ifdef ARB_PKT_LOCK_EN
            s  = (j / 2) % 4;
            ix = ((j / 2) / 4) * 2 + (j % 2);
`else
            s  = j % 4;
            ix = j / 4;
`endif
            check($sformatf("fair_beat%0d", j), 64'(q[j]),
                  64'({IW'(s), (ix % 2 == 1) ? 1'b1 : 1'b0, (32'(s) << 8) + 32'(ix)}));
        end

        // Backpressure: stream 1, 3 beats, m_tready toggling
        do_reset();
        rem[1] = 3; plen[1] = 3; base[1] = 32'h30;
        for (int c = 0; c < 16; c++) begin
            m_tready = (c < 6) ? pat[c] : 1'b1;
            tick();
        end
        check("bp_count", 64'(q.size()), 64'd3);
        for (int k = 0; k < 3 && k < q.size(); k++) begin
            check($sformatf("bp_beat%0d", k), 64'(q[k]),
                  64'({2'd1, (k == 2) ? 1'b1 : 1'b0, 32'h30 + 32'(k)}));
        end
        check("bp_pkt", 64'(pkt_cnt), 64'd1);

        // Reset in the middle of a stream-3 packet
        do_reset();
        rem[3] = 4; plen[3] = 4; base[3] = 32'h50;
        for (int c = 0; c < 20 && bidx[3] < 2; c++) tick();
        check("mid_two_beats", 64'(bidx[3]), 64'd2);
        rst_n   = 1'b0;
        stalled = 1'b0;
        drive_sources();
        @(negedge clk);
        check("mid_mvalid", 64'(m_tvalid), 64'd0);
        check("mid_grant", 64'(grant), 64'd0);
        check("mid_rdy", 64'(s_tready), 64'd0);
        rst_n = 1'b1;
        q.delete();
        rem[0] = 1; plen[0] = 1; base[0] = 32'h70;
        tick();
        check("mid_regrant", 64'(grant), 64'b0001);
        repeat (3) tick();
        check("mid_first_ok", 64'(q.size() >= 1), 64'd1);
        if (q.size() >= 1) check("mid_first", 64'(q[0]), 64'({2'd0, 1'b1, 32'h70}));

        // Counter wrap from a preloaded value
        do_reset();
        force dut.pkt_cnt_q = 16'hFFFE;
        #1;
        release dut.pkt_cnt_q;
        rem[0] = 1; plen[0] = 1; base[0] = 32'h90;
        repeat (4) tick();
        check("wrap_ffff", 64'(pkt_cnt), 64'hFFFF);
        rem[0] = 1;
        repeat (4) tick();
        check("wrap_zero", 64'(pkt_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
